// File: rtl/dxa_xfer_ctrl.sv
// DXA tile transfer sequencer: walks one 2-D tile descriptor element by element,
// moving each element between gmem lines and smem words with one read in flight.
module dxa_xfer_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int GMEM_BYTES  = 64,
  parameter int SMEM_BYTES  = 4,
  parameter int SMEM_ADDR_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               desc_valid,
  output logic                               desc_ready,
  input  logic                               desc_is_s2g,
  input  logic [ADDR_W-1:0]                  desc_gbase,
  input  logic [SMEM_ADDR_W-1:0]             desc_smem_base,
  input  logic [31:0]                        desc_coord0,
  input  logic [31:0]                        desc_coord1,
  input  logic [31:0]                        desc_size0,
  input  logic [31:0]                        desc_size1,
  input  logic [15:0]                        desc_tile0,
  input  logic [15:0]                        desc_tile1,
  input  logic [31:0]                        desc_stride0,
  input  logic [3:0]                         desc_elem_bytes,
  input  logic [63:0]                        desc_fill,
  output logic                               gmem_req_valid,
  input  logic                               gmem_req_ready,
  output logic                               gmem_req_rw,
  output logic [ADDR_W-$clog2(GMEM_BYTES)-1:0] gmem_req_addr,
  output logic [GMEM_BYTES-1:0]              gmem_req_byteen,
  output logic [GMEM_BYTES*8-1:0]            gmem_req_data,
  input  logic                               gmem_rsp_valid,
  output logic                               gmem_rsp_ready,
  input  logic [GMEM_BYTES*8-1:0]            gmem_rsp_data,
  output logic                               smem_req_valid,
  input  logic                               smem_req_ready,
  output logic                               smem_req_rw,
  output logic [SMEM_ADDR_W-$clog2(SMEM_BYTES)-1:0] smem_req_addr,
  output logic [SMEM_BYTES-1:0]              smem_req_byteen,
  output logic [SMEM_BYTES*8-1:0]            smem_req_data,
  input  logic                               smem_rsp_valid,
  output logic                               smem_rsp_ready,
  input  logic [SMEM_BYTES*8-1:0]            smem_rsp_data,
  output logic                               busy,
  output logic                               done_valid,
  output logic                               done_err,
  output logic [31:0]                        done_count
);
  localparam int GOFF_W = $clog2(GMEM_BYTES);
  localparam int SOFF_W = $clog2(SMEM_BYTES);
  localparam int GDW    = GMEM_BYTES * 8;
  localparam int SDW    = SMEM_BYTES * 8;

  typedef enum logic [2:0] {IDLE, EVAL, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
  state_t state, state_nx;

  logic                   is_s2g_q, err_q;
  logic [ADDR_W-1:0]      gbase_q, gaddr_q;
  logic [SMEM_ADDR_W-1:0] sbase_q, saddr_q;
  logic [31:0]            coord0_q, coord1_q, size0_q, size1_q, stride0_q;
  logic [31:0]            total_q, idx_q, y_q;
  logic [15:0]            tile0_q, x_q;
  logic [3:0]             eb_q;
  logic [63:0]            fill_q, elem_q;

  logic                   eb_ok, inb, at_end, adv;
  logic [31:0]            i0, i1;
  logic [ADDR_W-1:0]      gaddr_c;
  logic [SMEM_ADDR_W-1:0] saddr_c;
  logic [GOFF_W-1:0]      goff;
  logic [SOFF_W-1:0]      soff;
  logic [7:0]             emask;
  logic [63:0]            dmask, grd, srd;
  logic [GMEM_BYTES-1:0]  gmask;
  logic [SMEM_BYTES-1:0]  smask;
  logic                   src_rsp_fire, dst_req_fire, src_req_fire;

  assign eb_ok = (desc_elem_bytes == 4'd1 || desc_elem_bytes == 4'd2 ||
                  desc_elem_bytes == 4'd4 || desc_elem_bytes == 4'd8) &&
                 (32'(desc_elem_bytes) <= 32'(SMEM_BYTES));

  // x/y track idx % tile0 and idx / tile0 incrementally, avoiding a divider.
  assign i0      = coord0_q + {16'd0, x_q};
  assign i1      = coord1_q + y_q;
  assign inb     = (i0 < size0_q) && (i1 < size1_q);
  assign at_end  = (idx_q == total_q);
  assign gaddr_c = gbase_q + ADDR_W'(i0) * ADDR_W'(eb_q) + ADDR_W'(i1) * ADDR_W'(stride0_q);
  assign saddr_c = sbase_q + SMEM_ADDR_W'(idx_q) * SMEM_ADDR_W'(eb_q);

  assign goff  = gaddr_q[GOFF_W-1:0];
  assign soff  = saddr_q[SOFF_W-1:0];
  assign emask = 8'((9'd1 << eb_q) - 9'd1);
  assign dmask = (eb_q == 4'd8) ? '1 : ((64'd1 << {eb_q, 3'b000}) - 64'd1);
  assign gmask = GMEM_BYTES'(emask) << goff;
  assign smask = SMEM_BYTES'(emask) << soff;
  assign grd   = 64'(gmem_rsp_data >> {goff, 3'b000}) & dmask;
  assign srd   = 64'(smem_rsp_data >> {soff, 3'b000}) & dmask;

  assign src_req_fire = is_s2g_q ? (smem_req_valid && smem_req_ready) : (gmem_req_valid && gmem_req_ready);
  assign src_rsp_fire = is_s2g_q ? (smem_rsp_valid && smem_rsp_ready) : (gmem_rsp_valid && gmem_rsp_ready);
  assign dst_req_fire = is_s2g_q ? (gmem_req_valid && gmem_req_ready) : (smem_req_valid && smem_req_ready);
  assign adv = (state == EVAL && !at_end && !inb && is_s2g_q) || (state == WR_REQ && dst_req_fire);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    desc_ready      = 1'b0;
    busy            = 1'b1;
    done_valid      = 1'b0;
    done_err        = 1'b0;
    done_count      = '0;
    gmem_req_valid  = 1'b0;
    gmem_req_rw     = 1'b0;
    gmem_req_addr   = '0;
    gmem_req_byteen = '0;
    gmem_req_data   = '0;
    gmem_rsp_ready  = 1'b0;
    smem_req_valid  = 1'b0;
    smem_req_rw     = 1'b0;
    smem_req_addr   = '0;
    smem_req_byteen = '0;
    smem_req_data   = '0;
    smem_rsp_ready  = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        desc_ready = 1'b1;
        if (desc_valid) state_nx = eb_ok ? EVAL : DONE;
      end
      EVAL: begin
        if (at_end)        state_nx = DONE;
        else if (inb)      state_nx = RD_REQ;
        else if (!is_s2g_q) state_nx = WR_REQ;
      end
      RD_REQ: begin
        if (is_s2g_q) begin
          smem_req_valid  = 1'b1;
          smem_req_addr   = saddr_q[SMEM_ADDR_W-1:SOFF_W];
          smem_req_byteen = smask;
        end else begin
          gmem_req_valid  = 1'b1;
          gmem_req_addr   = gaddr_q[ADDR_W-1:GOFF_W];
          gmem_req_byteen = gmask;
        end
        if (src_req_fire) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        smem_rsp_ready = is_s2g_q;
        gmem_rsp_ready = !is_s2g_q;
        if (src_rsp_fire) state_nx = WR_REQ;
      end
      WR_REQ: begin
        if (is_s2g_q) begin
          gmem_req_valid  = 1'b1;
          gmem_req_rw     = 1'b1;
          gmem_req_addr   = gaddr_q[ADDR_W-1:GOFF_W];
          gmem_req_byteen = gmask;
          gmem_req_data   = GDW'(elem_q) << {goff, 3'b000};
        end else begin
          smem_req_valid  = 1'b1;
          smem_req_rw     = 1'b1;
          smem_req_addr   = saddr_q[SMEM_ADDR_W-1:SOFF_W];
          smem_req_byteen = smask;
          smem_req_data   = SDW'(elem_q) << {soff, 3'b000};
        end
        if (dst_req_fire) state_nx = EVAL;
      end
      DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
        done_count = idx_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && desc_valid) begin
        is_s2g_q  <= desc_is_s2g;
        gbase_q   <= desc_gbase;
        sbase_q   <= desc_smem_base;
        coord0_q  <= desc_coord0;
        coord1_q  <= desc_coord1;
        size0_q   <= desc_size0;
        size1_q   <= desc_size1;
        tile0_q   <= desc_tile0;
        stride0_q <= desc_stride0;
        eb_q      <= desc_elem_bytes;
        fill_q    <= desc_fill;
        total_q   <= 32'(desc_tile0) * 32'(desc_tile1);
        idx_q     <= '0;
        x_q       <= '0;
        y_q       <= '0;
        err_q     <= !eb_ok;
      end
      if (state == EVAL) begin
        gaddr_q <= gaddr_c;
        saddr_q <= saddr_c;
        if (!at_end && !inb && !is_s2g_q) elem_q <= fill_q;
      end
      if (state == RD_WAIT && src_rsp_fire) elem_q <= is_s2g_q ? srd : grd;
      if (adv) begin
        idx_q <= idx_q + 32'd1;
        if ({1'b0, x_q} + 17'd1 == {1'b0, tile0_q}) begin
          x_q <= '0;
          y_q <= y_q + 32'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dxa_xfer_ctrl.sv
// Directed bench for dxa_xfer_ctrl: copies, fill, skip, rejects, backpressure, mid-transfer reset.
module tb_dxa_xfer_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         desc_valid, desc_ready, desc_is_s2g;
  logic [31:0]  desc_gbase;
  logic [15:0]  desc_smem_base;
  logic [31:0]  desc_coord0, desc_coord1, desc_size0, desc_size1, desc_stride0;
  logic [15:0]  desc_tile0, desc_tile1;
  logic [3:0]   desc_elem_bytes;
  logic [63:0]  desc_fill;
  logic         gmem_req_valid, gmem_req_ready, gmem_req_rw;
  logic [25:0]  gmem_req_addr;
  logic [63:0]  gmem_req_byteen;
  logic [511:0] gmem_req_data, gmem_rsp_data;
  logic         gmem_rsp_valid, gmem_rsp_ready;
  logic         smem_req_valid, smem_req_ready, smem_req_rw;
  logic [13:0]  smem_req_addr;
  logic [3:0]   smem_req_byteen;
  logic [31:0]  smem_req_data, smem_rsp_data;
  logic         smem_rsp_valid, smem_rsp_ready;
  logic         busy, done_valid, done_err;
  logic [31:0]  done_count;

  int total = 0, bad = 0;
  int gf = 0, sf = 0, dn = 0;
  int g0, s0, d0;

  dxa_xfer_ctrl #(.ADDR_W(32), .GMEM_BYTES(64), .SMEM_BYTES(4), .SMEM_ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_is_s2g(desc_is_s2g),
    .desc_gbase(desc_gbase), .desc_smem_base(desc_smem_base),
    .desc_coord0(desc_coord0), .desc_coord1(desc_coord1),
    .desc_size0(desc_size0), .desc_size1(desc_size1),
    .desc_tile0(desc_tile0), .desc_tile1(desc_tile1),
    .desc_stride0(desc_stride0), .desc_elem_bytes(desc_elem_bytes), .desc_fill(desc_fill),
    .gmem_req_valid(gmem_req_valid), .gmem_req_ready(gmem_req_ready), .gmem_req_rw(gmem_req_rw),
    .gmem_req_addr(gmem_req_addr), .gmem_req_byteen(gmem_req_byteen), .gmem_req_data(gmem_req_data),
    .gmem_rsp_valid(gmem_rsp_valid), .gmem_rsp_ready(gmem_rsp_ready), .gmem_rsp_data(gmem_rsp_data),
    .smem_req_valid(smem_req_valid), .smem_req_ready(smem_req_ready), .smem_req_rw(smem_req_rw),
    .smem_req_addr(smem_req_addr), .smem_req_byteen(smem_req_byteen), .smem_req_data(smem_req_data),
    .smem_rsp_valid(smem_rsp_valid), .smem_rsp_ready(smem_rsp_ready), .smem_rsp_data(smem_rsp_data),
    .busy(busy), .done_valid(done_valid), .done_err(done_err), .done_count(done_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (gmem_req_valid && gmem_req_ready) gf <= gf + 1;
    if (smem_req_valid && smem_req_ready) sf <= sf + 1;
    if (done_valid) dn <= dn + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // 32-bit word k of gmem line L reads back as 0xA000_LLkk
  function automatic logic [511:0] gl(input logic [7:0] line);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = {8'hA0, 8'h00, line, 8'(k)};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_desc(input logic s2g, input logic [31:0] gbase, input logic [15:0] sbase,
                           input logic [31:0] sz0, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [3:0] eb, input logic [63:0] fill);
    desc_is_s2g = s2g; desc_gbase = gbase; desc_smem_base = sbase;
    desc_coord0 = 0; desc_coord1 = 0; desc_size0 = sz0; desc_size1 = 16;
    desc_tile0 = t0; desc_tile1 = t1; desc_stride0 = 32'h100;
    desc_elem_bytes = eb; desc_fill = fill;
    desc_valid = 1'b1;
    chk("desc_ready", desc_ready, 1);
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_g;
    for (int n = 0; n < 50 && !gmem_req_valid; n++) @(negedge clk);
  endtask
  task automatic wait_s;
    for (int n = 0; n < 50 && !smem_req_valid; n++) @(negedge clk);
  endtask

  task automatic gmem_read(input logic [25:0] line, input logic [63:0] be, input logic [511:0] rsp);
    wait_g();
    chk("g_rd_valid", gmem_req_valid, 1);
    chk("g_rd_rw", gmem_req_rw, 0);
    chk("g_rd_addr", gmem_req_addr, line);
    chk("g_rd_be", gmem_req_byteen, be);
    gmem_req_ready = 1'b1;
    @(negedge clk);
    gmem_req_ready = 1'b0;
    chk("g_rsp_ready", gmem_rsp_ready, 1);
    gmem_rsp_valid = 1'b1; gmem_rsp_data = rsp;
    @(negedge clk);
    gmem_rsp_valid = 1'b0;
  endtask

  task automatic smem_read(input logic [13:0] word, input logic [3:0] be, input logic [31:0] rsp);
    wait_s();
    chk("s_rd_valid", smem_req_valid, 1);
    chk("s_rd_rw", smem_req_rw, 0);
    chk("s_rd_addr", smem_req_addr, word);
    chk("s_rd_be", smem_req_byteen, be);
    smem_req_ready = 1'b1;
    @(negedge clk);
    smem_req_ready = 1'b0;
    chk("s_rsp_ready", smem_rsp_ready, 1);
    smem_rsp_valid = 1'b1; smem_rsp_data = rsp;
    @(negedge clk);
    smem_rsp_valid = 1'b0;
  endtask

  task automatic gmem_write(input logic [25:0] line, input logic [63:0] be, input logic [511:0] data);
    wait_g();
    chk("g_wr_valid", gmem_req_valid, 1);
    chk("g_wr_rw", gmem_req_rw, 1);
    chk("g_wr_addr", gmem_req_addr, line);
    chk("g_wr_be", gmem_req_byteen, be);
    chk("g_wr_data", gmem_req_data, data);
    gmem_req_ready = 1'b1;
    @(negedge clk);
    gmem_req_ready = 1'b0;
  endtask

  task automatic smem_write(input logic [13:0] word, input logic [3:0] be, input logic [31:0] data);
    wait_s();
    chk("s_wr_valid", smem_req_valid, 1);
    chk("s_wr_rw", smem_req_rw, 1);
    chk("s_wr_addr", smem_req_addr, word);
    chk("s_wr_be", smem_req_byteen, be);
    chk("s_wr_data", smem_req_data, data);
    smem_req_ready = 1'b1;
    @(negedge clk);
    smem_req_ready = 1'b0;
  endtask

  task automatic wait_done(input logic err, input logic [31:0] cnt);
    for (int n = 0; n < 50 && !done_valid; n++) @(negedge clk);
    chk("done_valid", done_valid, 1);
    chk("done_err", done_err, err);
    chk("done_count", done_count, cnt);
    @(negedge clk);
    chk("done_pulse_end", done_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b0; desc_valid = 0; desc_is_s2g = 0; desc_gbase = 0; desc_smem_base = 0;
    desc_coord0 = 0; desc_coord1 = 0; desc_size0 = 0; desc_size1 = 0; desc_tile0 = 0;
    desc_tile1 = 0; desc_stride0 = 0; desc_elem_bytes = 0; desc_fill = 0;
    gmem_req_ready = 0; gmem_rsp_valid = 0; gmem_rsp_data = 0;
    smem_req_ready = 0; smem_rsp_valid = 0; smem_rsp_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_g_valid", gmem_req_valid, 0);
    chk("rst_s_valid", smem_req_valid, 0);
    chk("rst_g_rsp_ready", gmem_rsp_ready, 0);
    chk("rst_s_rsp_ready", smem_rsp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done_valid, done_err, done_count}, 0);
    chk("rst_desc_ready", desc_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // 2x2 g2s copy, all in bounds
    send_desc(0, 32'h1000, 16'h0, 16, 2, 2, 4, 0);
    chk("t1_busy", busy, 1);
    gmem_read(26'h40, 64'h000F, gl(8'h40));
    smem_write(14'h0, 4'hF, 32'hA0004000);
    gmem_read(26'h40, 64'h00F0, gl(8'h40));
    smem_write(14'h1, 4'hF, 32'hA0004001);
    gmem_read(26'h44, 64'h000F, gl(8'h44));
    smem_write(14'h2, 4'hF, 32'hA0004400);
    gmem_read(26'h44, 64'h00F0, gl(8'h44));
    smem_write(14'h3, 4'hF, 32'hA0004401);
    wait_done(0, 4);

    // g2s with second element out of bounds -> filled, no gmem read
    g0 = gf;
    send_desc(0, 32'h1000, 16'h20, 1, 2, 1, 4, 64'hDEADBEEF);
    gmem_read(26'h40, 64'h000F, gl(8'h40));
    smem_write(14'h8, 4'hF, 32'hA0004000);
    smem_write(14'h9, 4'hF, 32'hDEADBEEF);
    wait_done(0, 2);
    chk("t2_gmem_fires", gf - g0, 1);

    // s2g same geometry -> one read, one write, second skipped
    g0 = gf; s0 = sf;
    send_desc(1, 32'h1000, 16'h20, 1, 2, 1, 4, 0);
    smem_read(14'h8, 4'hF, 32'h12345678);
    gmem_write(26'h40, 64'h000F, 512'h12345678);
    wait_done(0, 2);
    chk("t3_gmem_fires", gf - g0, 1);
    chk("t3_smem_fires", sf - s0, 1);

    // illegal element sizes and an empty tile
    g0 = gf; s0 = sf;
    send_desc(0, 32'h1000, 16'h0, 16, 2, 2, 3, 0);
    wait_done(1, 0);
    send_desc(0, 32'h1000, 16'h0, 16, 2, 2, 8, 0);
    wait_done(1, 0);
    send_desc(0, 32'h1000, 16'h0, 16, 0, 5, 4, 0);
    wait_done(0, 0);
    chk("t4_no_traffic", (gf - g0) + (sf - s0), 0);

    // backpressure on a 2-byte element at byte offset 6
    send_desc(0, 32'h1006, 16'h2, 16, 1, 1, 2, 0);
    wait_g();
    g0 = gf;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", gmem_req_valid, 1);
      chk("bp_addr", gmem_req_addr, 26'h40);
      chk("bp_be", gmem_req_byteen, 64'hC0);
      @(negedge clk);
    end
    chk("bp_no_fire", gf - g0, 0);
    gmem_read(26'h40, 64'hC0, gl(8'h40));
    chk("bp_one_fire", gf - g0, 1);
    smem_write(14'h0, 4'hC, 32'hA0000000);
    wait_done(0, 1);

    // reset while waiting for a read response
    send_desc(0, 32'h1000, 16'h0, 16, 1, 1, 4, 0);
    wait_g();
    gmem_req_ready = 1'b1;
    @(negedge clk);
    gmem_req_ready = 1'b0;
    chk("mr_rd_wait", gmem_rsp_ready, 1);
    s0 = sf; d0 = dn;
    reset = 1'b0; gmem_rsp_valid = 1'b1; gmem_rsp_data = gl(8'h40);
    @(negedge clk);
    chk("mr_outs", {gmem_req_valid, gmem_rsp_ready, smem_req_valid, smem_rsp_ready, busy, done_valid}, 0);
    reset = 1'b1;
    @(negedge clk);
    gmem_rsp_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mr_no_write", sf - s0, 0);
    chk("mr_no_done", dn - d0, 0);
    chk("mr_idle", busy, 0);
    send_desc(0, 32'h1000, 16'h0, 16, 1, 1, 4, 0);
    gmem_read(26'h40, 64'h000F, gl(8'h40));
    smem_write(14'h0, 4'hF, 32'hA0004000);
    wait_done(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
